// File: rtl/ws2812b_pkg.sv
// WS2812B driver shared types and timing defaults.
// 40 MHz clock assumed for the default cycle counts.
package ws2812b_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int T_BIT_DEF      = 50;
  localparam int T0H_DEF        = 16;
  localparam int T1H_DEF        = 32;
  localparam int RES_CYCLES_DEF = 2400;

  localparam int CH_G = 0;
  localparam int CH_R = 1;
  localparam int CH_B = 2;

  localparam int BITS_PER_LED = 24;

  function automatic logic [7:0] chan_byte(
    input logic       lit,
    input logic       en,
    input logic [7:0] val
  );
    return (lit && en) ? val : 8'h00;
  endfunction

endpackage

// File: rtl/ws2812b_bit_tx.sv
// WS2812B symbol generator: one T_BIT-cycle symbol per start pulse.
// A start on the done cycle chains symbols with no idle gap.
module ws2812b_bit_tx
  import ws2812b_pkg::*;
#(
  parameter int T_BIT = T_BIT_DEF,
  parameter int T0H   = T0H_DEF,
  parameter int T1H   = T1H_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic done
);

  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] TH0  = CW'(T0H);
  localparam logic [CW-1:0] TH1  = CW'(T1H);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] th;
  logic          bit_q;
  logic          active;
  logic          dout_q;
  logic          last;

  assign cnt_nxt = cnt + 1'b1;
  assign th      = bit_q ? TH1 : TH0;
  assign last    = active && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (res) begin
      cnt    <= '0;
      bit_q  <= 1'b0;
      active <= 1'b0;
      dout_q <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      bit_q  <= bit_val;
      active <= 1'b1;
      dout_q <= bit_val ? (T1H > 0) : (T0H > 0);
    end else if (active) begin
      if (last) begin
        active <= 1'b0;
        dout_q <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        dout_q <= (cnt_nxt < th);
      end
    end
  end

  assign dout = dout_q;
  assign done = last;

endmodule

// File: rtl/ws2812b_driver.sv
// WS2812B frame serializer: GRB per LED, LED 0 first, MSB first.
// Inputs are latched at frame start; frames repeat after a latch gap.
module ws2812b_driver
  import ws2812b_pkg::*;
#(
  parameter int         N_LEDS     = 12,
  parameter int         T_BIT      = T_BIT_DEF,
  parameter int         T0H        = T0H_DEF,
  parameter int         T1H        = T1H_DEF,
  parameter int         RES_CYCLES = RES_CYCLES_DEF,
  parameter logic [2:0] CH_EN      = 3'b111
) (
  input  logic              clk,
  input  logic              res,
  input  logic              enable,
  input  logic [N_LEDS-1:0] led_mask,
  input  logic [7:0]        intensity,
  output logic              dout,
  output logic              busy,
  output logic              frame_start
);

  localparam int GW = $clog2(RES_CYCLES);
  localparam int LW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(RES_CYCLES - 1);
  localparam logic [LW-1:0] LED_LAST = LW'(N_LEDS - 1);
  localparam logic [4:0]    BIT_LAST = 5'(BITS_PER_LED - 1);

  state_t            state;
  state_t            state_nxt;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_nxt;
  logic [LW-1:0]     led;
  logic [LW-1:0]     led_nxt;
  logic [4:0]        bit_idx;
  logic [4:0]        bit_nxt;
  logic [N_LEDS-1:0] mask_q;
  logic [7:0]        int_q;

  logic              gap_done;
  logic              latch;
  logic              tx_start;
  logic              tx_bit;
  logic              tx_done;
  logic              tx_dout;

  logic [LW-1:0]     sel_led;
  logic [4:0]        sel_bit;
  logic [N_LEDS-1:0] src_mask;
  logic [7:0]        src_int;
  logic [1:0]        ch;
  logic [2:0]        pos;
  logic              ch_on;
  logic [7:0]        byte_v;

  assign gap_done = (gap_cnt == GAP_LAST);
  assign latch    = (state == GAP) && gap_done && enable;

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    led_nxt   = led;
    bit_nxt   = bit_idx;
    tx_start  = 1'b0;
    sel_led   = '0;
    sel_bit   = '0;
    src_mask  = mask_q;
    src_int   = int_q;
    unique case (state)
      GAP: begin
        if (!gap_done) begin
          gap_nxt = gap_cnt + 1'b1;
        end else if (enable) begin
          // First symbol is launched from the live inputs being latched.
          state_nxt = SEND;
          led_nxt   = '0;
          bit_nxt   = '0;
          tx_start  = 1'b1;
          src_mask  = led_mask;
          src_int   = intensity;
        end
      end
      SEND: begin
        if (tx_done) begin
          if (bit_idx == BIT_LAST) begin
            bit_nxt = '0;
            if (led == LED_LAST) begin
              state_nxt = GAP;
              gap_nxt   = '0;
            end else begin
              led_nxt = led + 1'b1;
            end
          end else begin
            bit_nxt = bit_idx + 5'd1;
          end
          tx_start = !((bit_idx == BIT_LAST) && (led == LED_LAST));
          sel_led  = led_nxt;
          sel_bit  = bit_nxt;
        end
      end
    endcase
  end

  assign ch  = sel_bit[4:3];
  assign pos = 3'd7 - sel_bit[2:0];

  always_comb begin
    ch_on = 1'b0;
    case (ch)
      2'(CH_G): ch_on = CH_EN[2];
      2'(CH_R): ch_on = CH_EN[1];
      2'(CH_B): ch_on = CH_EN[0];
      default:  ch_on = 1'b0;
    endcase
  end

  assign byte_v = chan_byte(src_mask[sel_led], ch_on, src_int);
  assign tx_bit = byte_v[pos];

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= GAP;
      gap_cnt <= '0;
      led     <= '0;
      bit_idx <= '0;
      mask_q  <= '0;
      int_q   <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      led     <= led_nxt;
      bit_idx <= bit_nxt;
      if (latch) begin
        mask_q <= led_mask;
        int_q  <= intensity;
      end
    end
  end

  ws2812b_bit_tx #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_tx (
    .clk     (clk),
    .res     (res),
    .start   (tx_start && !res),
    .bit_val (tx_bit),
    .dout    (tx_dout),
    .done    (tx_done)
  );

  assign dout        = tx_dout;
  assign busy        = (state == SEND);
  assign frame_start = latch && !res;

endmodule

// File: tb/tb_ws2812b_driver.sv
// Self-checking bench for ws2812b_driver.
// Full-size instances run beside a 2-LED instance with a short gap.
module tb_ws2812b_driver;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] iv;
    int         longs;
  } vec_t;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       enable = 1'b1;
  logic [11:0] mask_m = 12'h001;
  logic [7:0]  int_m = 8'h01;
  logic [11:0] mask_r = 12'h001;
  logic [7:0]  int_r = 8'hFF;
  logic       res_s = 1'b1;
  logic       en_s = 1'b1;
  logic [1:0] mask_s = 2'b01;
  logic [7:0] int_s = 8'h01;

  logic dout_m, busy_m, fs_m;
  logic dout_r, busy_r, fs_r;
  logic dout_s, busy_s, fs_s;

  logic [2:0] dv, bv, fv, bq;
  int cyc = 0;
  int run [3];
  int nsym [3];
  int hl [3][288];
  int rise_c [3];
  int fall_c [3];
  int blen [3];
  int fs_c [3];
  int xcnt = 0;
  logic watch_x = 1'b0;

  int total = 0;
  int bad = 0;

  always #12.5 clk = ~clk;

  ws2812b_driver u_m (
    .clk(clk), .res(res), .enable(enable),
    .led_mask(mask_m), .intensity(int_m),
    .dout(dout_m), .busy(busy_m), .frame_start(fs_m)
  );

  ws2812b_driver #(.CH_EN(3'b010)) u_r (
    .clk(clk), .res(res), .enable(enable),
    .led_mask(mask_r), .intensity(int_r),
    .dout(dout_r), .busy(busy_r), .frame_start(fs_r)
  );

  ws2812b_driver #(.N_LEDS(2), .RES_CYCLES(64)) u_s (
    .clk(clk), .res(res_s), .enable(en_s),
    .led_mask(mask_s), .intensity(int_s),
    .dout(dout_s), .busy(busy_s), .frame_start(fs_s)
  );

  assign dv = {dout_s, dout_r, dout_m};
  assign bv = {busy_s, busy_r, busy_m};
  assign fv = {fs_s, fs_r, fs_m};

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bq = '0;
    for (int k = 0; k < 3; k++) begin
      run[k] = 0; nsym[k] = 0; rise_c[k] = 0;
      fall_c[k] = 0; blen[k] = 0; fs_c[k] = 0;
    end
  end

  always @(negedge clk) begin
    if (watch_x && $isunknown({dv, bv, fv})) xcnt <= xcnt + 1;
    for (int k = 0; k < 3; k++) begin
      if (fv[k]) begin
        nsym[k] <= 0;
        fs_c[k] <= cyc;
      end
      if (dv[k] === 1'b1) begin
        run[k] <= run[k] + 1;
      end else begin
        if (run[k] != 0 && nsym[k] < 288) begin
          hl[k][nsym[k]] <= run[k];
          nsym[k] <= nsym[k] + 1;
        end
        run[k] <= 0;
      end
      if (bv[k] && !bq[k]) rise_c[k] <= cyc;
      if (!bv[k] && bq[k]) begin
        fall_c[k] <= cyc;
        blen[k] <= cyc - rise_c[k];
      end
      bq[k] <= bv[k];
    end
  end

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [23:0] exp_led(logic lit, logic [7:0] iv,
                                          logic [2:0] ce);
    logic [7:0] g, r, b;
    g = (lit && ce[2]) ? iv : 8'h00;
    r = (lit && ce[1]) ? iv : 8'h00;
    b = (lit && ce[0]) ? iv : 8'h00;
    return {g, r, b};
  endfunction

  function automatic int count_long(int k);
    int n = 0;
    for (int j = 0; j < nsym[k]; j++)
      if (hl[k][j] == 32) n++;
    return n;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs(int k, int lim, string tag);
    logic ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (fv[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " frame_start seen"}, ok, 1'b1);
  endtask

  task automatic wait_fall(int k, int lim, string tag);
    logic ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (!bv[k]) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    check({tag, " busy fell"}, ok, 1'b1);
  endtask

  task automatic decode_check(int k, int n, logic [11:0] m,
                              logic [7:0] iv, logic [2:0] ce,
                              string tag);
    logic [23:0] v;
    logic        b;
    check({tag, " symbols"}, nsym[k], n * 24);
    for (int i = 0; i < n; i++) begin
      v = '0;
      for (int j = 0; j < 24; j++) begin
        if (hl[k][i*24+j] == 32) b = 1'b1;
        else if (hl[k][i*24+j] == 16) b = 1'b0;
        else b = 1'bx;
        v = {v[22:0], b};
      end
      check($sformatf("%s led%0d grb", tag, i), v,
            exp_led(m[i], iv, ce));
    end
  endtask

  task automatic main_seq();
    int r0;
    tick();
    tick();
    check("rst dout", dout_m, 1'b0);
    check("rst busy", busy_m, 1'b0);
    check("rst frame_start", fs_m, 1'b0);
    res = 1'b0;
    r0 = cyc;
    watch_x = 1'b1;
    wait_fs(0, 3000, "f1");
    check("f1 fs cycle", fs_c[0] - r0, 2399);
    check("f1 r-inst fs", fs_r, 1'b1);
    check("f1 dout low at fs", dout_m, 1'b0);
    tick();
    check("f1 dout high 1st send", dout_m, 1'b1);
    mask_m = 12'hFFF;
    int_m = 8'h20;
    wait_fall(0, 15000, "f1");
    check("f1 busy len", blen[0], 14400);
    decode_check(0, 12, 12'h001, 8'h01, 3'b111, "f1");
    check("f1 bit0 high", hl[0][0], 16);
    check("f1 bit7 high", hl[0][7], 32);
    check("f1 longs", count_long(0), 3);
    decode_check(1, 12, 12'h001, 8'hFF, 3'b010, "ronly");
    check("ronly longs", count_long(1), 8);
    wait_fs(0, 3000, "f2");
    tick();
    check("f2 gap", rise_c[0] - fall_c[0], 2400);
    wait_fall(0, 15000, "f2");
    decode_check(0, 12, 12'hFFF, 8'h20, 3'b111, "f2");
    check("f2 longs", count_long(0), 36);
    check("f2 bit2 long", hl[0][2], 32);
    check("f2 bit1 short", hl[0][1], 16);
    wait_fs(0, 3000, "f3");
    repeat (3000) tick();
    res = 1'b1;
    tick();
    check("midrst dout", dout_m, 1'b0);
    check("midrst busy", busy_m, 1'b0);
    res = 1'b0;
    r0 = cyc;
    wait_fs(0, 3000, "postrst");
    check("postrst fs cycle", fs_c[0] - r0, 2399);
  endtask

  task automatic small_seq();
    vec_t vt [6];
    int   n_fs;
    int   n_hi;
    vt[0] = '{2'b01, 8'h01, 3};
    vt[1] = '{2'b11, 8'h20, 6};
    vt[2] = '{2'b00, 8'hFF, 0};
    vt[3] = '{2'b11, 8'h00, 0};
    vt[4] = '{2'b10, 8'h81, 6};
    vt[5] = '{2'b01, 8'hFF, 24};
    tick();
    tick();
    check("s rst dout", dout_s, 1'b0);
    res_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mask_s = vt[i].mask;
      int_s = vt[i].iv;
      wait_fs(2, 200, $sformatf("v%0d", i));
      wait_fall(2, 3000, $sformatf("v%0d", i));
      check($sformatf("v%0d busy len", i), blen[2], 2400);
      decode_check(2, 2, {10'b0, vt[i].mask}, vt[i].iv, 3'b111,
                   $sformatf("v%0d", i));
      check($sformatf("v%0d longs", i), count_long(2), vt[i].longs);
    end
    mask_s = 2'b01;
    int_s = 8'h20;
    wait_fs(2, 200, "tear");
    repeat (1000) tick();
    mask_s = 2'b10;
    wait_fall(2, 3000, "tear");
    decode_check(2, 2, 12'h001, 8'h20, 3'b111, "tear cur");
    wait_fs(2, 200, "tear nxt");
    wait_fall(2, 3000, "tear nxt");
    decode_check(2, 2, 12'h002, 8'h20, 3'b111, "tear nxt");
    wait_fs(2, 200, "endrop");
    repeat (500) tick();
    en_s = 1'b0;
    wait_fall(2, 3000, "endrop");
    check("endrop busy len", blen[2], 2400);
    n_fs = 0;
    n_hi = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (fs_s !== 1'b0) n_fs++;
      if (dout_s !== 1'b0) n_hi++;
    end
    check("idle frame_start", n_fs, 0);
    check("idle dout", n_hi, 0);
    en_s = 1'b1;
    #1;
    check("reenable fs", fs_s, 1'b1);
    tick();
    check("reenable busy", busy_s, 1'b1);
    check("reenable dout", dout_s, 1'b1);
  endtask

  initial begin
    fork
      main_seq();
      small_seq();
    join
    check("no x", xcnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
